// File: rtl/dmem_responder_pkg.sv
// rtl/dmem_responder_pkg.sv - shared bus command codes, NOOP encoding and FSM state type
package dmem_responder_pkg;

    localparam logic [1:0]  BUS_NONE  = 2'h0;
    localparam logic [1:0]  BUS_LOAD  = 2'h1;
    localparam logic [1:0]  BUS_STORE = 2'h2;

    // addi x0, x0, 0
    localparam logic [31:0] NOOP_INST = 32'h00000013;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } dmem_state_e;

endpackage

// File: rtl/dmem_responder_if.sv
// rtl/dmem_responder_if.sv - instruction/data/loader bus bundle between core side and memory responder
//
// Signals:
//   pc_addr, im_command, instruction                          instruction fetch port
//   proc2Dmem_addr, proc2Dmem_command, proc2mem_data,
//   mem2proc_data                                             data load/store port
//   ld_valid, ld_ready, ld_addr, ld_data                      preload port (valid/ready)
//   init_done, err_cnt                                        status
// Modports: master = core/testbench side, slave = dmem_responder.
interface dmem_responder_if #(
    parameter int AW    = 10,
    parameter int ERR_W = 16
);
    logic [31:0]      pc_addr;
    logic [1:0]       im_command;
    logic [31:0]      instruction;

    logic [31:0]      proc2Dmem_addr;
    logic [1:0]       proc2Dmem_command;
    logic [31:0]      proc2mem_data;
    logic [31:0]      mem2proc_data;

    logic             ld_valid;
    logic             ld_ready;
    logic [AW-1:0]    ld_addr;
    logic [31:0]      ld_data;

    logic             init_done;
    logic [ERR_W-1:0] err_cnt;

    modport master (
        output pc_addr, im_command,
        output proc2Dmem_addr, proc2Dmem_command, proc2mem_data,
        output ld_valid, ld_addr, ld_data,
        input  instruction, mem2proc_data, ld_ready, init_done, err_cnt
    );

    modport slave (
        input  pc_addr, im_command,
        input  proc2Dmem_addr, proc2Dmem_command, proc2mem_data,
        input  ld_valid, ld_addr, ld_data,
        output instruction, mem2proc_data, ld_ready, init_done, err_cnt
    );

endinterface

// File: rtl/dmem_array.sv
// rtl/dmem_array.sv - DEPTH x 32 word storage, two asynchronous read ports, one synchronous write port
//
// Ports:
//   i_clk                    write clock
//   i_we, i_waddr, i_wdata   write port, committed at posedge
//   i_raddr_a, o_rdata_a     combinational read port A
//   i_raddr_b, o_rdata_b     combinational read port B
// Contents are not reset; a same-cycle read of the word being written returns the old value.
module dmem_array #(
    parameter int DEPTH = 1024,
    parameter int AW    = 10
) (
    input  logic          i_clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [31:0]   i_wdata,
    input  logic [AW-1:0] i_raddr_a,
    output logic [31:0]   o_rdata_a,
    input  logic [AW-1:0] i_raddr_b,
    output logic [31:0]   o_rdata_b
);

    logic [31:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata_a = r_mem[i_raddr_a];
    assign o_rdata_b = r_mem[i_raddr_b];

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - memory-side responder: clear sweep, fetch/load/store ports, preload port
//
// Ports:
//   clk   system clock
//   rst   asynchronous active-high reset; restarts the clear sweep
//   bus   dmem_responder_if.slave (fetch, data, loader and status signals)
// Optional feature: define DMEM_ERR_CNT_EN to count bad data accesses in err_cnt
// (saturating); otherwise err_cnt is tied to 0.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int AW    = 10,
    parameter int ERR_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    dmem_responder_if.slave  bus
);

    localparam logic [31:0] LP_BYTES = 32'(DEPTH * 4);

    dmem_state_e   r_state;
    dmem_state_e   w_state_nxt;
    logic [AW-1:0] r_clr_cnt;
    logic [AW-1:0] w_clr_cnt_nxt;

    logic          w_run;
    logic          w_pc_in;
    logic          w_d_in;
    logic          w_store;
    logic          w_ld_ready;

    logic          w_we;
    logic [AW-1:0] w_waddr;
    logic [31:0]   w_wdata;
    logic [31:0]   w_rdata_a;
    logic [31:0]   w_rdata_b;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= CLEAR;
            r_clr_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_clr_cnt <= w_clr_cnt_nxt;
        end
    end

    // Sweep walks every word once, then parks in RUN until the next reset
    always_comb begin
        w_state_nxt   = r_state;
        w_clr_cnt_nxt = r_clr_cnt;
        case (r_state)
            CLEAR: begin
                w_clr_cnt_nxt = r_clr_cnt + AW'(1);
                if (r_clr_cnt == AW'(DEPTH - 1)) begin
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                w_state_nxt = RUN;
            end
            default: begin
                w_state_nxt = CLEAR;
            end
        endcase
    end

    assign w_run   = (r_state == RUN);
    assign w_pc_in = (bus.pc_addr < LP_BYTES);
    assign w_d_in  = (bus.proc2Dmem_addr < LP_BYTES);

    // Misaligned in-range stores land on the aligned-down word
    assign w_store    = w_run && (bus.proc2Dmem_command == BUS_STORE) && w_d_in;
    assign w_ld_ready = w_run && (bus.proc2Dmem_command != BUS_STORE);

    // Single write port: sweep, then processor store, then loader
    always_comb begin
        w_we    = 1'b0;
        w_waddr = '0;
        w_wdata = '0;
        if (!w_run) begin
            w_we    = 1'b1;
            w_waddr = r_clr_cnt;
            w_wdata = '0;
        end else if (w_store) begin
            w_we    = 1'b1;
            w_waddr = bus.proc2Dmem_addr[AW+1:2];
            w_wdata = bus.proc2mem_data;
        end else if (bus.ld_valid && w_ld_ready) begin
            w_we    = 1'b1;
            w_waddr = bus.ld_addr;
            w_wdata = bus.ld_data;
        end
    end

    dmem_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .i_clk     (clk),
        .i_we      (w_we),
        .i_waddr   (w_waddr),
        .i_wdata   (w_wdata),
        .i_raddr_a (bus.pc_addr[AW+1:2]),
        .o_rdata_a (w_rdata_a),
        .i_raddr_b (bus.proc2Dmem_addr[AW+1:2]),
        .o_rdata_b (w_rdata_b)
    );

    assign bus.instruction   = (w_run && (bus.im_command == BUS_LOAD) && w_pc_in)
                             ? w_rdata_a : NOOP_INST;
    assign bus.mem2proc_data = (w_run && (bus.proc2Dmem_command == BUS_LOAD) && w_d_in)
                             ? w_rdata_b : 32'h0;
    assign bus.ld_ready      = w_ld_ready;
    assign bus.init_done     = w_run;

`ifdef DMEM_ERR_CNT_EN
    logic             w_bad;
    logic [ERR_W-1:0] r_err_cnt;

    assign w_bad = w_run
                && ((bus.proc2Dmem_command == BUS_LOAD) || (bus.proc2Dmem_command == BUS_STORE))
                && (!w_d_in || (bus.proc2Dmem_addr[1:0] != 2'b00));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err_cnt <= '0;
        end else if (w_bad && (r_err_cnt != {ERR_W{1'b1}})) begin
            r_err_cnt <= r_err_cnt + ERR_W'(1);
        end
    end

    assign bus.err_cnt = r_err_cnt;
`else
    // Byte offset only feeds the error counter, which is compiled out here
    logic w_unused_align;
    assign w_unused_align = &{1'b0, bus.proc2Dmem_addr[1:0]};
    assign bus.err_cnt    = '0;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - self-checking bench for dmem_responder
module tb_dmem_responder;
    import dmem_responder_pkg::*;

    logic clk;
    logic rst;
    int   n_pass;
    int   n_total;

    dmem_responder_if #(.AW(10), .ERR_W(16)) bus ();

    dmem_responder #(.DEPTH(1024), .AW(10), .ERR_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] pc;
        logic [1:0]  im_cmd;
        logic [31:0] daddr;
        logic [1:0]  dcmd;
        logic [31:0] exp_instr;
        logic [31:0] exp_rdata;
        logic        exp_ready;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic peek(input string name, input logic [31:0] addr, input logic [31:0] exp);
        bus.pc_addr    = addr;
        bus.im_command = BUS_LOAD;
        #1;
        chk(name, bus.instruction, exp);
    endtask

    task automatic load_word(input logic [9:0] idx, input logic [31:0] data);
        @(negedge clk);
        bus.ld_valid = 1'b1;
        bus.ld_addr  = idx;
        bus.ld_data  = data;
        #1;
        chk("loader_ready", {31'h0, bus.ld_ready}, 32'h1);
        @(negedge clk);
        bus.ld_valid = 1'b0;
    endtask

    task automatic count_init(input string name);
        int cnt;
        cnt = 0;
        while (!bus.init_done && cnt < 2000) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        chk(name, 32'(cnt), 32'd1024);
    endtask

    initial begin
        logic [31:0] exp_err;
        n_pass  = 0;
        n_total = 0;

        vecs[0] = '{"rd_idx3",      32'h0000000C, BUS_LOAD,  32'h0000000C, BUS_LOAD,  32'hDEADBEEF, 32'hDEADBEEF, 1'b1};
        vecs[1] = '{"rd_lowbits",   32'h0000000F, BUS_LOAD,  32'h00000028, BUS_LOAD,  32'hDEADBEEF, 32'hA5A50001, 1'b1};
        vecs[2] = '{"rd_top",       32'h00000FFC, BUS_LOAD,  32'h00000FFC, BUS_NONE,  32'hFFFF0000, 32'h00000000, 1'b1};
        vecs[3] = '{"pc_oor",       32'h00001000, BUS_LOAD,  32'h00000FFC, BUS_LOAD,  NOOP_INST,    32'hFFFF0000, 1'b1};
        vecs[4] = '{"im_none",      32'h0000000C, BUS_NONE,  32'h0000000C, 2'h3,      NOOP_INST,    32'h00000000, 1'b1};
        vecs[5] = '{"im_store",     32'h00000028, BUS_STORE, 32'h00000028, BUS_LOAD,  NOOP_INST,    32'hA5A50001, 1'b1};
        vecs[6] = '{"pc_high",      32'hFFFFFFFC, BUS_LOAD,  32'h00000000, BUS_LOAD,  NOOP_INST,    32'h00000000, 1'b1};
        vecs[7] = '{"im_reserved",  32'h00000FFC, 2'h3,      32'h0000000D, BUS_NONE,  NOOP_INST,    32'h00000000, 1'b1};

        rst                   = 1'b1;
        bus.pc_addr           = 32'h0;
        bus.im_command        = BUS_LOAD;
        bus.proc2Dmem_addr    = 32'h0;
        bus.proc2Dmem_command = BUS_NONE;
        bus.proc2mem_data     = 32'h0;
        bus.ld_valid          = 1'b0;
        bus.ld_addr           = '0;
        bus.ld_data           = 32'h0;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst_init_done", {31'h0, bus.init_done}, 32'h0);
        chk("rst_ld_ready",  {31'h0, bus.ld_ready},  32'h0);
        chk("rst_err_cnt",   {16'h0, bus.err_cnt},   32'h0);
        chk("rst_instr",     bus.instruction,        NOOP_INST);
        chk("rst_rdata",     bus.mem2proc_data,      32'h0);

        @(negedge clk);
        rst = 1'b0;
        count_init("init_latency");

        @(negedge clk);
        peek("swept_word5", 32'h14, 32'h0);

        load_word(10'd3, 32'hDEADBEEF);
        peek("loaded_idx3", 32'hC, 32'hDEADBEEF);
        load_word(10'd10,   32'hA5A50001);
        load_word(10'd1023, 32'hFFFF0000);

        foreach (vecs[i]) begin
            @(negedge clk);
            bus.pc_addr           = vecs[i].pc;
            bus.im_command        = vecs[i].im_cmd;
            bus.proc2Dmem_addr    = vecs[i].daddr;
            bus.proc2Dmem_command = vecs[i].dcmd;
            #1;
            chk({vecs[i].name, "_instr"}, bus.instruction,   vecs[i].exp_instr);
            chk({vecs[i].name, "_rdata"}, bus.mem2proc_data, vecs[i].exp_rdata);
            chk({vecs[i].name, "_ready"}, {31'h0, bus.ld_ready}, {31'h0, vecs[i].exp_ready});
        end

        // Read during write: old value visible this cycle, new value next cycle
        @(negedge clk);
        bus.proc2Dmem_command = BUS_STORE;
        bus.proc2Dmem_addr    = 32'h40;
        bus.proc2mem_data     = 32'h12345678;
        bus.pc_addr           = 32'h40;
        bus.im_command        = BUS_LOAD;
        #1;
        chk("rdw_old_instr", bus.instruction,   32'h0);
        chk("rdw_store_rd0", bus.mem2proc_data, 32'h0);
        chk("rdw_ld_block",  {31'h0, bus.ld_ready}, 32'h0);
        @(negedge clk);
        bus.proc2Dmem_command = BUS_LOAD;
        #1;
        chk("rdw_new_rdata", bus.mem2proc_data, 32'h12345678);
        chk("rdw_new_instr", bus.instruction,   32'h12345678);

        // Processor store beats loader; loader completes the following cycle
        @(negedge clk);
        bus.proc2Dmem_command = BUS_STORE;
        bus.proc2Dmem_addr    = 32'h44;
        bus.proc2mem_data     = 32'h11111111;
        bus.ld_valid          = 1'b1;
        bus.ld_addr           = 10'd20;
        bus.ld_data           = 32'h22222222;
        #1;
        chk("arb_ready_lo", {31'h0, bus.ld_ready}, 32'h0);
        @(negedge clk);
        bus.proc2Dmem_command = BUS_NONE;
        #1;
        chk("arb_ready_hi", {31'h0, bus.ld_ready}, 32'h1);
        peek("arb_ld_pending", 32'h50, 32'h0);
        @(negedge clk);
        bus.ld_valid = 1'b0;
        peek("arb_proc_word", 32'h44, 32'h11111111);
        peek("arb_ld_word",   32'h50, 32'h22222222);

        // Bad accesses: out-of-range load, out-of-range misaligned store, in-range misaligned store
        @(negedge clk);
        bus.proc2Dmem_command = BUS_LOAD;
        bus.proc2Dmem_addr    = 32'h1000;
        #1;
        chk("oor_load", bus.mem2proc_data, 32'h0);
        @(negedge clk);
        bus.proc2Dmem_command = BUS_STORE;
        bus.proc2Dmem_addr    = 32'h2002;
        bus.proc2mem_data     = 32'hBADBAD00;
        @(negedge clk);
        bus.proc2Dmem_addr    = 32'h4A;
        bus.proc2mem_data     = 32'h0000CAFE;
        @(negedge clk);
        bus.proc2Dmem_command = BUS_NONE;
`ifdef DMEM_ERR_CNT_EN
        exp_err = 32'd3;
`else
        exp_err = 32'd0;
`endif
        #1;
        chk("err_cnt", {16'h0, bus.err_cnt}, exp_err);
        peek("oor_store_drop", 32'h0,  32'h0);
        peek("misalign_word",  32'h48, 32'h0000CAFE);
        peek("misalign_next",  32'h4C, 32'h0);

        // Reset in the middle of the sweep
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst2_init_done", {31'h0, bus.init_done}, 32'h0);
        chk("rst2_err_cnt",   {16'h0, bus.err_cnt},   32'h0);
        @(negedge clk);
        rst = 1'b0;
        repeat (500) @(posedge clk);
        #1;
        chk("mid_clear_busy", {31'h0, bus.init_done}, 32'h0);
        rst = 1'b1;
        #1;
        chk("mid_rst_busy", {31'h0, bus.init_done}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        count_init("reinit_latency");
        @(negedge clk);
        peek("reswept_idx3", 32'hC, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
